// File: rtl/video_pocket_out.sv
// Pocket video output stage: RGB332 -> 24-bit RGB with a 2-cycle aligned pipeline,
// scaler-slot insertion after each line, test/blank overrides and geometry status.
module video_pocket_out #(
    parameter int EXP_H_ACTIVE = 800,
    parameter int EXP_V_ACTIVE = 720,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                   clk_pixel_i,
    input  logic                   rst_i,
    input  logic [7:0]             vid_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    input  logic [2:0]             scaler_slot_i,
    input  logic                   test_pat_i,
    input  logic                   blank_i,
    input  logic                   clr_err_i,
    output logic [23:0]            rgb_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   locked_o,
    output logic [10:0]            line_len_o,
    output logic [9:0]             frame_lines_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic [1:0]             err_o
);
    localparam logic [10:0] BAR_W = 11'(EXP_H_ACTIVE / 8);

    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t state;

    logic [10:0] h_pix;
    logic [9:0]  v_line, v_line_cl;
    logic        s1_de, s1_hs, s1_vs;
    logic [7:0]  s1_pix, bar_pix, src_pix;
    logic [2:0]  s1_slot;
    logic [10:0] bar_q;
    logic        de_fall, new_line_err, new_frame_err;

    function automatic logic [23:0] expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3],
                p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

    // s1_de is the previous de_i, so a fall is visible on the first low input cycle
    assign de_fall  = s1_de & ~de_i;
    assign locked_o = (state == LOCKED);

    always_comb begin
        bar_q = h_pix / BAR_W;
        case ((bar_q > 11'd7) ? 3'd7 : bar_q[2:0])
            3'd0:    bar_pix = 8'hFF;
            3'd1:    bar_pix = 8'hFC;
            3'd2:    bar_pix = 8'h1F;
            3'd3:    bar_pix = 8'h1C;
            3'd4:    bar_pix = 8'hE3;
            3'd5:    bar_pix = 8'hE0;
            3'd6:    bar_pix = 8'h03;
            default: bar_pix = 8'h00;
        endcase
        src_pix = blank_i ? 8'h00 : (test_pat_i ? bar_pix : vid_i);
    end

    always_comb begin
        v_line_cl     = (de_fall && v_line != 10'h3FF) ? v_line + 10'd1 : v_line;
        new_line_err  = de_fall && (state == LOCKED) && (h_pix != 11'(EXP_H_ACTIVE));
        new_frame_err = vs_i && (state == LOCKED) && (v_line_cl != 10'(EXP_V_ACTIVE));
    end

    always_ff @(posedge clk_pixel_i or posedge rst_i) begin
        if (rst_i) state <= UNLOCKED;
        else if (vs_i) state <= LOCKED;
    end

    always_ff @(posedge clk_pixel_i or posedge rst_i) begin
        if (rst_i) begin
            s1_de   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_pix  <= '0;
            s1_slot <= '0;
            de_o    <= 1'b0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
            rgb_o   <= '0;
        end else begin
            s1_de   <= de_i;
            s1_hs   <= hs_i;
            s1_vs   <= vs_i;
            s1_pix  <= src_pix;
            s1_slot <= scaler_slot_i;
            de_o    <= (state == LOCKED) && s1_de;
            hs_o    <= s1_hs;
            vs_o    <= s1_vs;
            // de_o here is still the previous output, so the slot lands on the first low cycle
            if ((state == LOCKED) && s1_de) rgb_o <= expand(s1_pix);
            else if (!s1_de && de_o)        rgb_o <= {10'd0, s1_slot, 11'd0};
            else                            rgb_o <= '0;
        end
    end

    always_ff @(posedge clk_pixel_i or posedge rst_i) begin
        if (rst_i) begin
            h_pix         <= '0;
            v_line        <= '0;
            line_len_o    <= '0;
            frame_lines_o <= '0;
            frame_cnt_o   <= '0;
            err_o         <= '0;
        end else begin
            if (de_i) begin
                if (h_pix != 11'h7FF) h_pix <= h_pix + 11'd1;
            end else begin
                h_pix <= '0;
            end
            // h_pix already holds the full line count on the fall cycle
            if (de_fall) line_len_o <= h_pix;
            if (vs_i) begin
                frame_lines_o <= v_line_cl;
                v_line        <= '0;
                frame_cnt_o   <= frame_cnt_o + 1'b1;
            end else begin
                v_line <= v_line_cl;
            end
            err_o <= (err_o & ~{2{clr_err_i}}) | {new_line_err, new_frame_err};
        end
    end
endmodule

// File: tb/tb_video_pocket_out.sv
// Scoreboard bench for video_pocket_out: per-cycle expected outputs queued at drive
// time and compared two cycles later; geometry/status checked at line/frame ends.
module tb_video_pocket_out;
    logic        clk_pixel_i = 1'b0;
    logic        rst_i;
    logic [7:0]  vid_i;
    logic        de_i, hs_i, vs_i;
    logic [2:0]  scaler_slot_i;
    logic        test_pat_i, blank_i, clr_err_i;
    logic [23:0] rgb_o;
    logic        de_o, hs_o, vs_o, locked_o;
    logic [10:0] line_len_o;
    logic [9:0]  frame_lines_o;
    logic [15:0] frame_cnt_o;
    logic [1:0]  err_o;

    video_pocket_out dut (
        .clk_pixel_i(clk_pixel_i), .rst_i(rst_i), .vid_i(vid_i), .de_i(de_i),
        .hs_i(hs_i), .vs_i(vs_i), .scaler_slot_i(scaler_slot_i),
        .test_pat_i(test_pat_i), .blank_i(blank_i), .clr_err_i(clr_err_i),
        .rgb_o(rgb_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .locked_o(locked_o),
        .line_len_o(line_len_o), .frame_lines_o(frame_lines_o),
        .frame_cnt_o(frame_cnt_o), .err_o(err_o)
    );

    always #5 clk_pixel_i = ~clk_pixel_i;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        m_locked = 1'b0;
    logic        m_prev_de = 1'b0;
    int          m_hpix = 0;
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb332(input logic [7:0] p);
        logic [2:0] r, g;
        logic [1:0] b;
        r = p[7:5]; g = p[4:2]; b = p[1:0];
        return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    task automatic step(input logic d, input logic [7:0] v, input logic h, input logic s);
        exp_t e, got_e;
        logic [23:0] pix;
        int bar;
        de_i = d; vid_i = v; hs_i = h; vs_i = s;
        if (s) m_locked = 1'b1;
        bar = (m_hpix / 100 > 7) ? 7 : m_hpix / 100;
        pix = blank_i ? 24'h0 : (test_pat_i ? bar_rgb[bar] : rgb332(v));
        e.de = m_locked & d;
        e.hs = h;
        e.vs = s;
        if (e.de)                            e.rgb = pix;
        else if (m_locked && !d && m_prev_de) e.rgb = {10'd0, scaler_slot_i, 11'd0};
        else                                 e.rgb = 24'h0;
        m_prev_de = e.de;
        m_hpix = d ? ((m_hpix < 2047) ? m_hpix + 1 : 2047) : 0;
        sb.push_back(e);
        @(posedge clk_pixel_i);
        @(negedge clk_pixel_i);
        if (sb.size() == 2) begin
            got_e = sb.pop_front();
            chk("pipe", 64'({de_o, hs_o, vs_o, rgb_o}), 64'(got_e));
        end
    endtask

    // n DE cycles, then the fall cycle (optionally with vs / clr_err), then gap idle cycles
    task automatic line(input int n, input bit rnd, input logic [7:0] v,
                        input logic vs_fall, input logic clr_fall, input int gap);
        for (int i = 0; i < n; i++)
            step(1'b1, rnd ? 8'($urandom) : v, (i == 2), 1'b0);
        clr_err_i = clr_fall;
        step(1'b0, 8'h00, 1'b0, vs_fall);
        clr_err_i = 1'b0;
        for (int i = 0; i < gap; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1; vid_i = 0; de_i = 0; hs_i = 0; vs_i = 0;
        scaler_slot_i = 0; test_pat_i = 0; blank_i = 0; clr_err_i = 0;
        repeat (3) @(negedge clk_pixel_i);
        chk("rst_rgb", 64'(rgb_o), 64'h0);
        chk("rst_sync", 64'({de_o, hs_o, vs_o, locked_o}), 64'h0);
        chk("rst_geom", 64'({line_len_o, frame_lines_o, frame_cnt_o, err_o}), 64'h0);
        rst_i = 1'b0;

        // unlocked: DE toggles but nothing is shown
        for (int k = 0; k < 3; k++) line(10, 1'b0, 8'hFF, 1'b0, 1'b0, 3);
        chk("unlk_locked", 64'(locked_o), 64'h0);
        chk("unlk_err", 64'(err_o), 64'h0);

        step(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("lock", 64'(locked_o), 64'h1);
        chk("lock_fcnt", 64'(frame_cnt_o), 64'h1);

        scaler_slot_i = 3'd5;
        line(800, 1'b0, 8'hE0, 1'b0, 1'b0, 4);
        chk("len800", 64'(line_len_o), 64'd800);
        chk("err_ok", 64'(err_o), 64'h0);
        scaler_slot_i = 3'd2;
        line(800, 1'b1, 8'h00, 1'b0, 1'b0, 4);
        test_pat_i = 1'b1;
        line(800, 1'b0, 8'h5A, 1'b0, 1'b0, 4);
        blank_i = 1'b1;
        line(800, 1'b0, 8'h5A, 1'b0, 1'b0, 4);
        blank_i = 1'b0; test_pat_i = 1'b0; scaler_slot_i = 3'd7;
        line(799, 1'b1, 8'h00, 1'b0, 1'b0, 4);
        chk("len799", 64'(line_len_o), 64'd799);
        chk("len_err", 64'(err_o), 64'h2);

        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("f5_lines", 64'(frame_lines_o), 64'd5);
        chk("f5_err", 64'(err_o), 64'h3);
        chk("f5_fcnt", 64'(frame_cnt_o), 64'd2);
        clr_err_i = 1'b1; step(1'b0, 8'h00, 1'b0, 1'b0); clr_err_i = 1'b0;
        chk("clr1", 64'(err_o), 64'h0);

        for (int k = 0; k < 718; k++) line(4, 1'b1, 8'h00, 1'b0, 1'b0, 1);
        line(4, 1'b1, 8'h00, 1'b0, 1'b1, 1);
        chk("err_wins", 64'(err_o), 64'h2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("f719_lines", 64'(frame_lines_o), 64'd719);
        chk("f719_err", 64'(err_o), 64'h3);
        chk("f719_fcnt", 64'(frame_cnt_o), 64'd3);
        clr_err_i = 1'b1; step(1'b0, 8'h00, 1'b0, 1'b0); clr_err_i = 1'b0;
        chk("clr2", 64'(err_o), 64'h0);

        for (int k = 0; k < 719; k++) line(4, 1'b1, 8'h00, 1'b0, 1'b0, 1);
        line(4, 1'b1, 8'h00, 1'b1, 1'b0, 2);
        chk("f720_lines", 64'(frame_lines_o), 64'd720);
        chk("f720_err0", 64'(err_o[0]), 64'h0);
        chk("f720_fcnt", 64'(frame_cnt_o), 64'd4);

        // async reset in the middle of a line
        for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_out", 64'({de_o, rgb_o}), 64'h0);
        chk("arst_stat", 64'({locked_o, frame_cnt_o, err_o}), 64'h0);
        de_i = 1'b0;
        sb.delete();
        m_locked = 1'b0; m_prev_de = 1'b0; m_hpix = 0;
        repeat (2) @(negedge clk_pixel_i);
        rst_i = 1'b0;
        line(20, 1'b0, 8'hFF, 1'b0, 1'b0, 3);
        chk("post_rst_locked", 64'(locked_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
